lzd_norm_shift: RTL and testbench
=================================

// Module: lzd_norm_shift
// PURPOSE
//  Consumes the 1-based leading-one position from the leading-zero detector and normalizes
//  the 66-bit adder sum. It left-shifts the sum so its leading one lands in bit W-1 and
//  lowers the exponent by the same amount. Two-stage pipeline with valid/ready handshakes
//  on both sides, placed between the LZD and the rounding stage of the FP MAC datapath.
// PARAMETERS
//  W      66  sum/mantissa width
//  POS_W  7   width of LZD position (1..W, 1 = MSB set)
//  EXP_W  12  unsigned biased exponent width
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      block can accept a beat this cycle
//  in_sum     in   W      unnormalized sum
//  in_pos     in   POS_W  LZD position; shift = in_pos-1
//  in_exp     in   EXP_W  pre-normalization exponent
//  out_valid  out  1      output beat valid
//  out_ready  in   1      downstream accepts the beat
//  out_mant   out  W      normalized mantissa
//  out_exp    out  EXP_W  adjusted exponent
//  out_zero   out  1      result is exactly zero
//  out_uf     out  1      exponent underflow; result flushed
//  out_err    out  1      in_pos out of range (0 or >W)
// BEHAVIOUR
//  Reset: both stage valid bits are 0, and out_valid, out_mant, out_exp, out_zero, out_uf
//   and out_err are all 0. Reset aborts any in-flight beats with no partial output.
//  Transfer rules: an input beat transfers when in_valid&in_ready; an output beat when
//   out_valid&out_ready. out_valid is driven directly from the stage-2 valid register.
//  Stage advance: s2 loads when (!s2_valid | out_ready). s1 loads when (!s1_valid | s2 loads).
//   in_ready = !s1_valid | s2_loads, a combinational ready chain.
//  Stall: while out_valid=1 and out_ready=0, all outputs hold stable.
//  Latency is 2 cycles from input transfer to out_valid when out_ready is held at 1.
//   Throughput is 1 beat/cycle. The block holds at most 2 beats; order is preserved.
//  Stage 1 (registered):
//   - zero  = (in_sum == 0). Checked independently of in_pos, because the LZD reports W
//     for both 0 and 1.
//   - err   = (in_pos == 0) | (in_pos > W).
//   - sh    = in_pos - 1, computed only when err = 0.
//   - coarse shift: s1_sum = in_sum << {sh[6:3], 3'b000}.
//   - in_exp, sh[2:0] and the flags are registered alongside s1_sum.
//  Stage 2 (registered, output):
//   - mant = s1_sum << sh[2:0]. Bits shifted out above W-1 are discarded (always zero for
//     a correct in_pos).
//   - uf   = !zero & !err & (exp < sh), using an unsigned compare at EXP_W+1 bits.
//   - exp  = exp - sh when there is no underflow.
//  Output priority, first match wins:
//   1. err  -> mant=0, exp=0, zero=0, uf=0, err=1.
//   2. zero -> mant=0, exp=0, zero=1.
//   3. uf   -> mant=0, exp=0, uf=1.
//   4. otherwise the normal result; exp == sh gives exp=0 with no uf.
//  Out of scope: the block does not verify that in_pos matches in_sum; in_pos is trusted.
//  Simultaneous input accept and output drain in the same cycle with both stages full must
//   sustain full throughput with no bubble.
// TESTING
//  1. sum=1<<65, pos=1, exp=5 -> after 2 cycles mant=1<<65, exp=5, flags 0.
//  2. sum=66'h1, pos=66, exp=100 -> mant=1<<65, exp=35, uf=0.
//     Then sum=66'h1, pos=66, exp=10 -> uf=1, mant=0, exp=0.
//  3. sum=0, pos=66, exp=40 -> zero=1, mant=0, exp=0.
//     Then pos=0 or pos=67 with any sum -> err=1, mant=0.
//  4. Back-to-back: 8 beats on consecutive cycles with out_ready=1, pos sweeping 1..8 ->
//     8 consecutive out_valid cycles starting 2 cycles after the first accept, in order,
//     each mant with MSB set.
//  5. Backpressure: out_ready=0 while 3 beats are offered ->
//     - 2 beats are accepted, then in_ready=0 and the outputs hold stable;
//     - on raising out_ready, all 3 beats emerge in order, none lost or duplicated.
//  6. Reset mid-flight: rst_n=0 with 2 beats in flight -> out_valid=0 at once and in_ready=1
//     after release; the next beat has latency 2 and shows no stale data.

Source files
------------

// File: rtl/lzd_norm_shift.sv
// -----------------------------------------------------------------------------
// lzd_norm_shift
// Normalization stage of the FP MAC datapath. It takes the unnormalized adder
// sum together with the 1-based leading-one position reported by the LZD. The
// sum is left-shifted so that its leading one lands in bit W-1, and the
// exponent is lowered by the same amount. The block is a two-stage pipeline
// with valid/ready handshakes on both sides.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   block can accept a beat this cycle (combinational ready chain)
//   in_sum     unnormalized sum (W bits)
//   in_pos     LZD leading-one position, 1 = MSB set; shift = in_pos-1
//   in_exp     pre-normalization biased exponent
//   out_valid  output beat valid (stage-2 valid register)
//   out_ready  downstream accepts the beat
//   out_mant   normalized mantissa
//   out_exp    adjusted exponent
//   out_zero   result is exactly zero
//   out_uf     exponent underflow, result flushed to zero
//   out_err    in_pos out of range (0 or > W)
// -----------------------------------------------------------------------------
module lzd_norm_shift #(
    parameter int W     = 66,
    parameter int POS_W = 7,
    parameter int EXP_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_sum,
    input  logic [POS_W-1:0] in_pos,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_zero,
    output logic             out_uf,
    output logic             out_err
);

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(W);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    // Handshake / pipeline control
    logic s2_load_s;
    logic s1_load_s;
    logic in_xfer_s;

    // Stage-1 combinational results
    logic             s1_err_s;
    logic             s1_zero_s;
    logic [POS_W-1:0] s1_sh_s;
    logic [POS_W-1:0] s1_coarse_s;
    logic [W-1:0]     s1_sum_s;

    // Stage-1 registers
    logic             s1_valid_r;
    logic [W-1:0]     s1_sum_r;
    logic [EXP_W-1:0] s1_exp_r;
    logic [POS_W-1:0] s1_sh_r;
    logic             s1_zero_r;
    logic             s1_err_r;

    // Stage-2 combinational results
    logic [W-1:0]     s2_mant_s;
    logic             s2_uf_s;
    logic [EXP_W-1:0] s2_exp_diff_s;
    logic [W-1:0]     s2_mant_next_s;
    logic [EXP_W-1:0] s2_exp_next_s;
    logic             s2_zero_next_s;
    logic             s2_uf_next_s;
    logic             s2_err_next_s;

    // Ready chain: stage 2 frees up when empty or draining; stage 1 when empty
    // or moving into stage 2. A full pipe therefore accepts and drains together.
    assign s2_load_s = !out_valid || out_ready;
    assign s1_load_s = !s1_valid_r || s2_load_s;
    assign in_ready  = s1_load_s;
    assign in_xfer_s = in_valid && s1_load_s;

    // Stage 1: range check, zero detect and coarse (multiple-of-8) shift.
    // Zero is detected from the sum itself because the LZD reports W for both
    // a zero sum and a sum of one.
    always_comb begin
        s1_err_s  = (in_pos == {POS_W{1'b0}}) || (in_pos > POS_MAX);
        s1_zero_s = (in_sum == {W{1'b0}});
        if (s1_err_s) begin
            s1_sh_s = {POS_W{1'b0}};
        end else begin
            s1_sh_s = in_pos - POS_ONE;
        end
        s1_coarse_s = {s1_sh_s[POS_W-1:3], 3'b000};
        s1_sum_s    = in_sum << s1_coarse_s;
    end

    // Stage-1 register: valid follows the load enable, payload loads on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_sum_r   <= {W{1'b0}};
            s1_exp_r   <= {EXP_W{1'b0}};
            s1_sh_r    <= {POS_W{1'b0}};
            s1_zero_r  <= 1'b0;
            s1_err_r   <= 1'b0;
        end else begin
            if (s1_load_s) begin
                s1_valid_r <= in_valid;
            end
            if (in_xfer_s) begin
                s1_sum_r  <= s1_sum_s;
                s1_exp_r  <= in_exp;
                s1_sh_r   <= s1_sh_s;
                s1_zero_r <= s1_zero_s;
                s1_err_r  <= s1_err_s;
            end
        end
    end

    // Stage 2: fine shift (0..7), underflow test at EXP_W+1 bits and the
    // output priority mux (err, then zero, then underflow, then normal).
    always_comb begin
        s2_mant_s      = s1_sum_r << s1_sh_r[2:0];
        s2_uf_s        = !s1_zero_r && !s1_err_r &&
                         ({1'b0, s1_exp_r} < (EXP_W+1)'(s1_sh_r));
        s2_exp_diff_s  = s1_exp_r - EXP_W'(s1_sh_r);
        s2_mant_next_s = {W{1'b0}};
        s2_exp_next_s  = {EXP_W{1'b0}};
        s2_zero_next_s = 1'b0;
        s2_uf_next_s   = 1'b0;
        s2_err_next_s  = 1'b0;
        if (s1_err_r) begin
            s2_err_next_s = 1'b1;
        end else if (s1_zero_r) begin
            s2_zero_next_s = 1'b1;
        end else if (s2_uf_s) begin
            s2_uf_next_s = 1'b1;
        end else begin
            s2_mant_next_s = s2_mant_s;
            s2_exp_next_s  = s2_exp_diff_s;
        end
    end

    // Stage-2 / output register: payload only changes when a valid beat moves
    // in, so outputs stay stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_mant  <= {W{1'b0}};
            out_exp   <= {EXP_W{1'b0}};
            out_zero  <= 1'b0;
            out_uf    <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            if (s2_load_s) begin
                out_valid <= s1_valid_r;
            end
            if (s2_load_s && s1_valid_r) begin
                out_mant <= s2_mant_next_s;
                out_exp  <= s2_exp_next_s;
                out_zero <= s2_zero_next_s;
                out_uf   <= s2_uf_next_s;
                out_err  <= s2_err_next_s;
            end
        end
    end

endmodule

// File: tb/tb_lzd_norm_shift.sv
// -----------------------------------------------------------------------------
// tb_lzd_norm_shift
// Self-checking bench for lzd_norm_shift: a table of directed vectors, hand
// sequences for back-to-back, backpressure and mid-flight reset, and a
// randomized run scored against a simple arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_lzd_norm_shift;

    localparam int W     = 66;
    localparam int POS_W = 7;
    localparam int EXP_W = 12;

    typedef struct {
        logic [W-1:0]     sum;
        logic [POS_W-1:0] pos;
        logic [EXP_W-1:0] exp;
        logic [W-1:0]     mant;
        logic [EXP_W-1:0] oexp;
        logic             zero;
        logic             uf;
        logic             err;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_sum;
    logic [POS_W-1:0] in_pos;
    logic [EXP_W-1:0] in_exp;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_mant;
    logic [EXP_W-1:0] out_exp;
    logic             out_zero;
    logic             out_uf;
    logic             out_err;

    int errors;
    int checks;
    int cyc;
    int out_cnt;
    bit rand_ready;
    bit rand_gap;
    bit ready_val;
    bit chk_lat;

    vec_t drv_q[$];
    vec_t sb_q[$];
    int   acc_q[$];

    lzd_norm_shift #(.W(W), .POS_W(POS_W), .EXP_W(EXP_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_pos    (in_pos),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_zero  (out_zero),
        .out_uf    (out_uf),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: one full shift by pos-1, then the flag priority.
    function automatic vec_t model(input logic [W-1:0] sum, input logic [POS_W-1:0] pos,
                                   input logic [EXP_W-1:0] exp);
        vec_t v;
        int   sh;
        v.sum = sum; v.pos = pos; v.exp = exp;
        v.mant = '0; v.oexp = '0; v.zero = 1'b0; v.uf = 1'b0; v.err = 1'b0;
        if (pos == 0 || int'(pos) > W) begin
            v.err = 1'b1;
        end else if (sum == 0) begin
            v.zero = 1'b1;
        end else begin
            sh = int'(pos) - 1;
            if (int'(exp) < sh) begin
                v.uf = 1'b1;
            end else begin
                v.mant = sum << sh;
                v.oexp = EXP_W'(int'(exp) - sh);
            end
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One clock: drive after the rising edge, account handshakes at the falling edge.
    task automatic tick();
        vec_t e;
        int   lat;
        @(posedge clk);
        cyc++;
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
        if (drv_q.size() > 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
            in_valid = 1'b1;
            in_sum   = drv_q[0].sum;
            in_pos   = drv_q[0].pos;
            in_exp   = drv_q[0].exp;
        end else begin
            in_valid = 1'b0;
        end
        @(negedge clk);
        if (in_valid && in_ready) begin
            sb_q.push_back(drv_q.pop_front());
            acc_q.push_back(cyc);
        end
        if (out_valid && out_ready) begin
            out_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got mant=%0h with no beat pending expected none", out_mant);
            end else begin
                e   = sb_q.pop_front();
                lat = cyc - acc_q.pop_front();
                check("result", {out_mant, out_exp, out_zero, out_uf, out_err},
                      {e.mant, e.oexp, e.zero, e.uf, e.err});
                if (chk_lat) check("latency", 128'(lat), 128'(2));
            end
        end
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((drv_q.size() > 0 || sb_q.size() > 0) && n < bound) begin
            tick();
            n++;
        end
        check("drain_done", 128'(drv_q.size() + sb_q.size()), 128'(0));
    endtask

    vec_t          tbl[10];
    vec_t          v;
    logic [95:0]   r;
    logic [W-1:0]  hold_mant;
    logic [EXP_W-1:0] hold_exp;
    int            k;
    int            base;
    bit            hist[10];

    initial begin
        errors = 0; checks = 0; cyc = 0; out_cnt = 0;
        rand_ready = 1'b0; rand_gap = 1'b0; ready_val = 1'b1; chk_lat = 1'b1;
        rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; in_pos = '0; in_exp = '0; out_ready = 1'b1;

        // sum, pos, exp, mant, oexp, zero, uf, err
        tbl[0] = '{66'h20000000000000000, 7'd1,  12'd5,    66'h20000000000000000, 12'd5,    1'b0, 1'b0, 1'b0};
        tbl[1] = '{66'h1,                 7'd66, 12'd100,  66'h20000000000000000, 12'd35,   1'b0, 1'b0, 1'b0};
        tbl[2] = '{66'h1,                 7'd66, 12'd10,   66'h0,                 12'd0,    1'b0, 1'b1, 1'b0};
        tbl[3] = '{66'h0,                 7'd66, 12'd40,   66'h0,                 12'd0,    1'b1, 1'b0, 1'b0};
        tbl[4] = '{66'h5,                 7'd0,  12'd7,    66'h0,                 12'd0,    1'b0, 1'b0, 1'b1};
        tbl[5] = '{66'h20000000000000000, 7'd67, 12'd7,    66'h0,                 12'd0,    1'b0, 1'b0, 1'b1};
        tbl[6] = '{66'h0,                 7'd0,  12'd9,    66'h0,                 12'd0,    1'b0, 1'b0, 1'b1};
        tbl[7] = '{66'h1,                 7'd66, 12'd65,   66'h20000000000000000, 12'd0,    1'b0, 1'b0, 1'b0};
        tbl[8] = '{66'hC00,               7'd55, 12'd200,  66'h30000000000000000, 12'd146,  1'b0, 1'b0, 1'b0};
        tbl[9] = '{66'h3FFFFFFFFFFFFFFFF, 7'd1,  12'd4095, 66'h3FFFFFFFFFFFFFFFF, 12'd4095, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_outputs", {out_mant, out_exp, out_zero, out_uf, out_err}, 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(1));

        // Directed table, one beat at a time, latency checked
        for (int i = 0; i < 10; i++) begin
            drv_q.push_back(tbl[i]);
            drain(20);
        end

        // Back-to-back: 8 beats, pos 1..8
        for (int i = 1; i <= 8; i++) begin
            drv_q.push_back(model(66'(1) << (W - i), 7'(i), 12'(300 + i)));
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            hist[i] = out_valid;
            if (out_valid) check("b2b_msb", 128'(out_mant[W-1]), 128'(1));
        end
        for (int i = 0; i < 10; i++) check("b2b_valid", 128'(hist[i]), 128'(i >= 2));
        drain(20);

        // Backpressure: 3 beats offered with out_ready low
        chk_lat = 1'b0;
        ready_val = 1'b0;
        for (int i = 3; i <= 5; i++) drv_q.push_back(model(66'(3) << (W - i - 1), 7'(i), 12'(50 * i)));
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 2) begin
                hold_mant = out_mant;
                hold_exp  = out_exp;
            end
            if (i > 2) check("stall_hold", {out_mant, out_exp}, {hold_mant, hold_exp});
        end
        check("bp_accepted", 128'(sb_q.size()), 128'(2));
        check("bp_in_ready", 128'(in_ready), 128'(0));
        check("bp_out_valid", 128'(out_valid), 128'(1));
        base = out_cnt;
        ready_val = 1'b1;
        drain(20);
        check("bp_emerged", 128'(out_cnt - base), 128'(3));

        // Reset with two beats in flight
        ready_val = 1'b0;
        drv_q.push_back(model(66'h20000000000000000, 7'd1, 12'd77));
        drv_q.push_back(model(66'h10000000000000000, 7'd2, 12'd78));
        repeat (3) tick();
        check("rf_inflight", 128'(sb_q.size()), 128'(2));
        #2;
        rst_n = 1'b0;
        #1;
        check("rf_out_valid", 128'(out_valid), 128'(0));
        sb_q.delete(); acc_q.delete(); drv_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rf_in_ready", 128'(in_ready), 128'(1));
        ready_val = 1'b1;
        chk_lat = 1'b1;
        drv_q.push_back(model(66'h800, 7'd55, 12'd60));
        drain(20);

        // Randomized run against the reference model
        chk_lat = 1'b0;
        rand_ready = 1'b1;
        rand_gap = 1'b1;
        for (int i = 0; i < 400; i++) begin
            r = {$urandom(), $urandom(), $urandom()};
            case ($urandom_range(0, 9))
                0: v = model('0, 7'd66, 12'($urandom_range(0, 4095)));
                1: v = model(r[W-1:0], ($urandom_range(0, 1) != 0) ? 7'd0 : 7'($urandom_range(67, 127)),
                             12'($urandom_range(0, 4095)));
                2: v = model(r[W-1:0], 7'($urandom_range(1, 66)), 12'($urandom_range(0, 4095)));
                default: begin
                    k = $urandom_range(0, W - 1);
                    v = model((r[W-1:0] & ((66'(1) << k) - 66'(1))) | (66'(1) << k), 7'(W - k),
                              ($urandom_range(0, 1) != 0) ? 12'($urandom_range(0, 80)) : 12'($urandom_range(0, 4095)));
                end
            endcase
            drv_q.push_back(v);
        end
        drain(6000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
